core_debug_frame_bridge: RTL and testbench
==========================================

// Module: core_debug_frame_bridge
// PURPOSE
//  Byte-stream front end for the core debug unit. Assembles 6-byte command frames from a
//  UART/JTAG byte link, issues each as one iCMD_* request to core_debug, then waits for its
//  response. Returns a 5-byte response frame to the link. Sits directly upstream of core_debug.
//  Commands that never produce a response are closed by a timeout.
// PARAMETERS
//  P_TIMEOUT   1024   cycles in WAIT_RESP before a timeout response is sent (>=2)
//  P_SYNC      4'hA   required upper nibble of frame byte 0
// PORTS
//  iCLOCK          in   1   sole clock, all logic on rising edge
//  iRESET_SYNC     in   1   synchronous reset, active-high
//  iRX_VALID       in   1   link byte valid
//  oRX_BUSY        out  1   link backpressure; byte taken when iRX_VALID && !oRX_BUSY
//  iRX_DATA        in   8   link byte
//  oTX_VALID       out  1   response byte valid; byte taken when oTX_VALID && !iTX_BUSY
//  iTX_BUSY        in   1   link transmitter busy
//  oTX_DATA        out  8   response byte
//  oCMD_REQ        out  1   request to core_debug
//  iCMD_BUSY       in   1   core_debug busy; request accepted when oCMD_REQ && !iCMD_BUSY
//  oCMD_COMMAND    out  4   command code (byte0[3:0])
//  oCMD_TARGET     out  8   register target (byte1)
//  oCMD_DATA       out  32  command data (bytes2..5, big-endian)
//  iRESP_VALID     in   1   core_debug response strobe
//  iRESP_ERROR     in   1   core_debug response error
//  iRESP_DATA      in   32  core_debug response data
//  oDROP_COUNT     out  8   saturating count of discarded bad header bytes
// BEHAVIOUR
//  - Reset (sync, one cycle is sufficient): state=RX_HDR.
//    oRX_BUSY=0, oTX_VALID=0, oTX_DATA=0, oCMD_REQ=0, oCMD_COMMAND/TARGET/DATA=0, oDROP_COUNT=0.
//    Asserted mid-frame or mid-response, it abandons the transaction; no partial TX bytes follow.
//  - States: RX_HDR -> RX_TGT -> RX_DATA(x4) -> ISSUE -> WAIT_RESP -> TX(x5) -> RX_HDR.
//  - RX_HDR: oRX_BUSY=0. Accepted byte with [7:4]==P_SYNC latches COMMAND=[3:0] -> RX_TGT.
//    Otherwise the byte is discarded, oDROP_COUNT+1 (holds at 8'hFF), and the state stays RX_HDR.
//  - RX_TGT/RX_DATA: oRX_BUSY=0; each accepted byte is stored.
//    Data is MSB first; a 2-bit byte counter advances only on accept.
//    After the 4th data byte -> ISSUE. No inter-byte timeout.
//  - ISSUE..TX: oRX_BUSY=1.
//  - ISSUE: oCMD_REQ=1 (registered), COMMAND/TARGET/DATA stable.
//    Hold until a cycle with !iCMD_BUSY; in that cycle the request is accepted.
//    Next cycle oCMD_REQ=0, state WAIT_RESP, timer cleared.
//    iRESP_VALID is ignored in ISSUE.
//  - WAIT_RESP: timer increments each cycle.
//    iRESP_VALID=1 -> latch status={P_SYNC^4'hF,2'b00,1'b0,iRESP_ERROR} and data=iRESP_DATA -> TX.
//    Else when timer==P_TIMEOUT-1 -> status={P_SYNC^4'hF,2'b00,1'b1,1'b0}, data=0 -> TX.
//    Response and timeout in the same cycle: the response wins.
//  - TX: oTX_VALID=1, byte order status, D[31:24], D[23:16], D[15:8], D[7:0].
//    Byte held stable while iTX_BUSY. Index advances on accept.
//    After the 5th accept -> RX_HDR (oTX_VALID=0) the following cycle.
//  - Latency: request issued the cycle after the last data byte accept (iCMD_BUSY=0).
//    First TX byte is valid the cycle after iRESP_VALID.
//  - Stray iRESP_VALID outside WAIT_RESP is ignored. Widths fixed; no arithmetic beyond
//    the counters. Timer width $clog2(P_TIMEOUT).
// STRUCTURE
//  - Shared include core_debug.h holds:
//    - CORE_DEBUG_CMD_* codes and frame constants (CMD_LEN=6, RESP_LEN=5).
//    - Status bit positions: STAT_ERR=0, STAT_TIMEOUT=1.
//  - One sub-module: core_debug_resp_serializer (status+32-bit word -> 5-byte valid/busy stream).
//    The bridge FSM holds RX assembly, issue and wait.
// TESTING
//  - Frame A0 05 00 00 00 00, core model acks read after 2 cycles with 32'h12345678:
//    one oCMD_REQ (COMMAND=0, TARGET=5); TX bytes 50 12 34 56 78.
//  - Bytes 33 7F then AF 00 00 00 00 00:
//    oDROP_COUNT=2; STOP command issued; on core ack TX = 50 00 00 00 00.
//  - iCMD_BUSY held high 10 cycles in ISSUE:
//    oCMD_REQ stays 1 with stable fields; request accepted on cycle 11; single request only.
//  - A1 00 DE AD BE EF with no response:
//    after P_TIMEOUT cycles TX = 52 00 00 00 00; next frame is accepted normally.
//  - iTX_BUSY toggled randomly during TX:
//    each byte held until accepted; no byte lost or duplicated.
//  - iRESET_SYNC pulsed after 3 RX bytes and again during TX byte 2:
//    all outputs return to reset values; no further TX bytes; next full frame works.

Source files
------------

// File: rtl/core_debug_frame_bridge_pkg.sv
// rtl/core_debug_frame_bridge_pkg.sv - frame constants, command codes, status layout and FSM state type for the debug bridge
package core_debug_frame_bridge_pkg;

    localparam int CMD_LEN  = 6;
    localparam int RESP_LEN = 5;

    localparam int STAT_ERR     = 0;
    localparam int STAT_TIMEOUT = 1;

    localparam logic [3:0] CORE_DEBUG_CMD_READ  = 4'h0;
    localparam logic [3:0] CORE_DEBUG_CMD_WRITE = 4'h1;
    localparam logic [3:0] CORE_DEBUG_CMD_STOP  = 4'hF;

    typedef enum logic [2:0] {
        ST_RX_HDR,
        ST_RX_TGT,
        ST_RX_DATA,
        ST_ISSUE,
        ST_WAIT_RESP,
        ST_TX
    } bridge_state_t;

    // Status byte: inverted sync nibble on top so the host can tell responses from commands.
    function automatic logic [7:0] resp_status(input logic [3:0] sync,
                                               input logic       timeout,
                                               input logic       err);
        logic [7:0] s;
        s               = {sync ^ 4'hF, 4'h0};
        s[STAT_TIMEOUT] = timeout;
        s[STAT_ERR]     = err;
        return s;
    endfunction

endpackage

// File: rtl/core_debug_resp_serializer.sv
// rtl/core_debug_resp_serializer.sv - turns a status byte plus 32-bit word into a 5-byte valid/busy byte stream
module core_debug_resp_serializer
    import core_debug_frame_bridge_pkg::*;
(
    input  logic        iCLOCK,
    input  logic        iRESET_SYNC,
    input  logic        iLOAD,
    input  logic [7:0]  iSTATUS,
    input  logic [31:0] iDATA,
    output logic        oTX_VALID,
    input  logic        iTX_BUSY,
    output logic [7:0]  oTX_DATA,
    output logic        oDONE
);

    logic [31:0] word_q;
    logic [2:0]  idx_q;
    logic        accept;

    assign accept = oTX_VALID && !iTX_BUSY;
    assign oDONE  = accept && (idx_q == 3'(RESP_LEN - 1));

    // Load a response, then shift out the word MSB first, one byte per link accept.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            oTX_VALID <= 1'b0;
            oTX_DATA  <= 8'h00;
            word_q    <= 32'h0;
            idx_q     <= 3'd0;
        end else if (iLOAD) begin
            oTX_VALID <= 1'b1;
            oTX_DATA  <= iSTATUS;
            word_q    <= iDATA;
            idx_q     <= 3'd0;
        end else if (accept) begin
            if (oDONE) begin
                oTX_VALID <= 1'b0;
                oTX_DATA  <= 8'h00;
                idx_q     <= 3'd0;
            end else begin
                oTX_DATA  <= word_q[31:24];
                word_q    <= {word_q[23:0], 8'h00};
                idx_q     <= idx_q + 3'd1;
            end
        end
    end

endmodule

// File: rtl/core_debug_frame_bridge.sv
// rtl/core_debug_frame_bridge.sv - assembles 6-byte debug command frames, issues them to core_debug and returns 5-byte responses
module core_debug_frame_bridge
    import core_debug_frame_bridge_pkg::*;
#(
    parameter int         P_TIMEOUT = 1024,
    parameter logic [3:0] P_SYNC    = 4'hA
) (
    input  logic        iCLOCK,
    input  logic        iRESET_SYNC,
    input  logic        iRX_VALID,
    output logic        oRX_BUSY,
    input  logic [7:0]  iRX_DATA,
    output logic        oTX_VALID,
    input  logic        iTX_BUSY,
    output logic [7:0]  oTX_DATA,
    output logic        oCMD_REQ,
    input  logic        iCMD_BUSY,
    output logic [3:0]  oCMD_COMMAND,
    output logic [7:0]  oCMD_TARGET,
    output logic [31:0] oCMD_DATA,
    input  logic        iRESP_VALID,
    input  logic        iRESP_ERROR,
    input  logic [31:0] iRESP_DATA,
    output logic [7:0]  oDROP_COUNT
);

    localparam int TMR_W = $clog2(P_TIMEOUT);

    bridge_state_t    state;
    logic [1:0]       byte_cnt;
    logic [TMR_W-1:0] timer;
    logic             rx_accept;
    logic             resp_timeout;
    logic             resp_load;
    logic [7:0]       resp_stat;
    logic [31:0]      resp_word;
    logic             tx_done;

    assign rx_accept    = iRX_VALID && !oRX_BUSY;
    assign resp_timeout = (timer == TMR_W'(P_TIMEOUT - 1));
    // A real response beats a timeout landing in the same cycle.
    assign resp_load    = (state == ST_WAIT_RESP) && (iRESP_VALID || resp_timeout);
    assign resp_stat    = iRESP_VALID ? resp_status(P_SYNC, 1'b0, iRESP_ERROR)
                                      : resp_status(P_SYNC, 1'b1, 1'b0);
    assign resp_word    = iRESP_VALID ? iRESP_DATA : 32'h0;

    // Frame assembly, request issue and response wait; TX progress comes back from the serializer.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state        <= ST_RX_HDR;
            oRX_BUSY     <= 1'b0;
            oCMD_REQ     <= 1'b0;
            oCMD_COMMAND <= 4'h0;
            oCMD_TARGET  <= 8'h00;
            oCMD_DATA    <= 32'h0;
            oDROP_COUNT  <= 8'h00;
            byte_cnt     <= 2'd0;
            timer        <= '0;
        end else begin
            case (state)
                ST_RX_HDR: begin
                    if (rx_accept) begin
                        if (iRX_DATA[7:4] == P_SYNC) begin
                            oCMD_COMMAND <= iRX_DATA[3:0];
                            state        <= ST_RX_TGT;
                        end else if (oDROP_COUNT != 8'hFF) begin
                            oDROP_COUNT <= oDROP_COUNT + 8'd1;
                        end
                    end
                end
                ST_RX_TGT: begin
                    if (rx_accept) begin
                        oCMD_TARGET <= iRX_DATA;
                        byte_cnt    <= 2'd0;
                        state       <= ST_RX_DATA;
                    end
                end
                ST_RX_DATA: begin
                    if (rx_accept) begin
                        oCMD_DATA <= {oCMD_DATA[23:0], iRX_DATA};
                        byte_cnt  <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'(CMD_LEN - 3)) begin
                            oRX_BUSY <= 1'b1;
                            oCMD_REQ <= 1'b1;
                            state    <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (!iCMD_BUSY) begin
                        oCMD_REQ <= 1'b0;
                        timer    <= '0;
                        state    <= ST_WAIT_RESP;
                    end
                end
                ST_WAIT_RESP: begin
                    timer <= timer + 1'b1;
                    if (resp_load) begin
                        state <= ST_TX;
                    end
                end
                ST_TX: begin
                    if (tx_done) begin
                        oRX_BUSY <= 1'b0;
                        state    <= ST_RX_HDR;
                    end
                end
                default: state <= ST_RX_HDR;
            endcase
        end
    end

    core_debug_resp_serializer u_resp_serializer (
        .iCLOCK      (iCLOCK),
        .iRESET_SYNC (iRESET_SYNC),
        .iLOAD       (resp_load),
        .iSTATUS     (resp_stat),
        .iDATA       (resp_word),
        .oTX_VALID   (oTX_VALID),
        .iTX_BUSY    (iTX_BUSY),
        .oTX_DATA    (oTX_DATA),
        .oDONE       (tx_done)
    );

endmodule

// File: tb/tb_core_debug_frame_bridge.sv
// tb/tb_core_debug_frame_bridge.sv - randomized self-checking bench for core_debug_frame_bridge
module tb_core_debug_frame_bridge;
    import core_debug_frame_bridge_pkg::*;

    localparam int         TMO  = 1024;
    localparam logic [3:0] SYNC = 4'hA;

    logic        iCLOCK = 1'b0;
    logic        iRESET_SYNC = 1'b1;
    logic        iRX_VALID = 1'b0;
    logic        oRX_BUSY;
    logic [7:0]  iRX_DATA = 8'h00;
    logic        oTX_VALID;
    logic        iTX_BUSY = 1'b0;
    logic [7:0]  oTX_DATA;
    logic        oCMD_REQ;
    logic        iCMD_BUSY = 1'b0;
    logic [3:0]  oCMD_COMMAND;
    logic [7:0]  oCMD_TARGET;
    logic [31:0] oCMD_DATA;
    logic        iRESP_VALID = 1'b0;
    logic        iRESP_ERROR = 1'b0;
    logic [31:0] iRESP_DATA = 32'h0;
    logic [7:0]  oDROP_COUNT;

    always #5 iCLOCK = ~iCLOCK;

    core_debug_frame_bridge #(.P_TIMEOUT(TMO), .P_SYNC(SYNC)) dut (
        .iCLOCK(iCLOCK), .iRESET_SYNC(iRESET_SYNC),
        .iRX_VALID(iRX_VALID), .oRX_BUSY(oRX_BUSY), .iRX_DATA(iRX_DATA),
        .oTX_VALID(oTX_VALID), .iTX_BUSY(iTX_BUSY), .oTX_DATA(oTX_DATA),
        .oCMD_REQ(oCMD_REQ), .iCMD_BUSY(iCMD_BUSY), .oCMD_COMMAND(oCMD_COMMAND),
        .oCMD_TARGET(oCMD_TARGET), .oCMD_DATA(oCMD_DATA),
        .iRESP_VALID(iRESP_VALID), .iRESP_ERROR(iRESP_ERROR), .iRESP_DATA(iRESP_DATA),
        .oDROP_COUNT(oDROP_COUNT)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: frame parser, pending request, response wait and expected TX bytes
    int          ncyc = 0;
    bit          seen_reset = 1'b0;
    bit          prev_reset = 1'b0;
    bit          prev_req = 1'b0;
    bit          mbusy;
    logic [7:0]  frame_q[$];
    bit          exp_req = 1'b0;
    logic [3:0]  exp_cmd;
    logic [7:0]  exp_tgt;
    logic [31:0] exp_data;
    bit          waiting = 1'b0;
    int          wait_start = 0;
    logic [7:0]  exp_tx[$];
    int          exp_drop = 0;

    // Observed DUT transactions for the literal checks
    logic [7:0]  tx_log[$];
    int          req_count = 0;
    int          req_rise_n = 0;
    int          req_acc_n = 0;
    logic [3:0]  acc_cmd;
    logic [7:0]  acc_tgt;
    logic [31:0] acc_data;
    bit          tx_rand = 1'b0;

    // Compare DUT against model on every falling edge, then advance model by the coming rising edge
    always @(negedge iCLOCK) begin
        ncyc++;
        mbusy = exp_req || waiting || (exp_tx.size() != 0);
        if (seen_reset) begin
            chk("rx_busy", 64'(oRX_BUSY), 64'(mbusy));
            chk("drop_count", 64'(oDROP_COUNT), 64'(exp_drop));
            chk("cmd_req", 64'(oCMD_REQ), 64'(exp_req));
            if (exp_req) begin
                chk("cmd_command", 64'(oCMD_COMMAND), 64'(exp_cmd));
                chk("cmd_target", 64'(oCMD_TARGET), 64'(exp_tgt));
                chk("cmd_data", 64'(oCMD_DATA), 64'(exp_data));
            end
            chk("tx_valid", 64'(oTX_VALID), 64'(exp_tx.size() != 0));
            if (exp_tx.size() != 0) chk("tx_data", 64'(oTX_DATA), 64'(exp_tx[0]));
            if (prev_reset) begin
                chk("reset_tx_data", 64'(oTX_DATA), 64'd0);
                chk("reset_command", 64'(oCMD_COMMAND), 64'd0);
                chk("reset_target", 64'(oCMD_TARGET), 64'd0);
                chk("reset_data", 64'(oCMD_DATA), 64'd0);
            end
        end
        if (iRESET_SYNC) begin
            frame_q.delete();
            exp_tx.delete();
            exp_req  = 1'b0;
            waiting  = 1'b0;
            exp_drop = 0;
            seen_reset = 1'b1;
        end else if (seen_reset) begin
            if (oTX_VALID && !iTX_BUSY) tx_log.push_back(oTX_DATA);
            if (oCMD_REQ && !prev_req) req_rise_n = ncyc;
            if (oCMD_REQ && !iCMD_BUSY) begin
                req_count++;
                req_acc_n = ncyc;
                acc_cmd   = oCMD_COMMAND;
                acc_tgt   = oCMD_TARGET;
                acc_data  = oCMD_DATA;
            end
            if (exp_tx.size() != 0 && !iTX_BUSY) void'(exp_tx.pop_front());
            if (waiting && ncyc > wait_start) begin
                if (iRESP_VALID) begin
                    exp_tx.push_back({~SYNC, 3'b000, iRESP_ERROR});
                    exp_tx.push_back(iRESP_DATA[31:24]);
                    exp_tx.push_back(iRESP_DATA[23:16]);
                    exp_tx.push_back(iRESP_DATA[15:8]);
                    exp_tx.push_back(iRESP_DATA[7:0]);
                    waiting = 1'b0;
                end else if (ncyc - wait_start == TMO) begin
                    exp_tx.push_back({~SYNC, 4'b0010});
                    for (int i = 0; i < 4; i++) exp_tx.push_back(8'h00);
                    waiting = 1'b0;
                end
            end
            if (exp_req && !iCMD_BUSY) begin
                exp_req    = 1'b0;
                waiting    = 1'b1;
                wait_start = ncyc;
            end
            if (iRX_VALID && !mbusy) begin
                if (frame_q.size() == 0 && iRX_DATA[7:4] != SYNC) begin
                    if (exp_drop < 255) exp_drop++;
                end else begin
                    frame_q.push_back(iRX_DATA);
                    if (frame_q.size() == CMD_LEN) begin
                        exp_cmd  = frame_q[0][3:0];
                        exp_tgt  = frame_q[1];
                        exp_data = {frame_q[2], frame_q[3], frame_q[4], frame_q[5]};
                        exp_req  = 1'b1;
                        frame_q.delete();
                    end
                end
            end
        end
        prev_reset = iRESET_SYNC;
        prev_req   = oCMD_REQ;
    end

    // Link transmitter backpressure
    initial begin
        forever begin
            @(posedge iCLOCK); #1;
            iTX_BUSY = tx_rand ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge iCLOCK); #1;
    endtask

    function automatic bit model_busy();
        return exp_req || waiting || (exp_tx.size() != 0);
    endfunction

    task automatic send_byte(input logic [7:0] b);
        bit acc;
        int t;
        repeat ($urandom_range(0, 1)) tick();
        iRX_VALID = 1'b1;
        iRX_DATA  = b;
        acc = 1'b0;
        t = 0;
        while (!acc && t < 200) begin
            acc = !model_busy();
            tick();
            t++;
        end
        if (!acc) chk("rx_accept_wait", 64'd0, 64'd1);
        iRX_VALID = 1'b0;
    endtask

    task automatic send_garbage();
        logic [7:0] b;
        b = 8'($urandom);
        if (b[7:4] == SYNC) b[7:4] = 4'h3;
        send_byte(b);
    endtask

    task automatic stray_resp();
        iRESP_VALID = 1'b1;
        iRESP_DATA  = $urandom;
        tick();
        iRESP_VALID = 1'b0;
    endtask

    task automatic start_frame(input logic [7:0] f[6], input int busy_n, input bit stray,
                               input bit resp_en, input int dly, input logic [31:0] rdata,
                               input bit rerr);
        int t;
        iCMD_BUSY = (busy_n > 0);
        for (int i = 0; i < 6; i++) send_byte(f[i]);
        if (busy_n > 0) begin
            for (int i = 0; i < busy_n; i++) begin
                iRESP_VALID = stray && (i == 2);
                tick();
            end
            iRESP_VALID = 1'b0;
            iCMD_BUSY   = 1'b0;
        end
        t = 0;
        while (!waiting && t < 100) begin
            tick();
            t++;
        end
        chk("request_accepted", 64'(waiting), 64'd1);
        if (resp_en) begin
            repeat (dly) tick();
            iRESP_VALID = 1'b1;
            iRESP_ERROR = rerr;
            iRESP_DATA  = rdata;
            tick();
            iRESP_VALID = 1'b0;
            iRESP_ERROR = 1'b0;
            iRESP_DATA  = $urandom;
        end
    endtask

    task automatic finish_frame();
        int t;
        t = 0;
        while (model_busy() && t < TMO + 300) begin
            tick();
            t++;
        end
        chk("frame_complete", 64'(model_busy()), 64'd0);
    endtask

    task automatic check_tx(input string name, input int mark, input logic [7:0] e0,
                            input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3,
                            input logic [7:0] e4);
        logic [7:0] e[5];
        e = '{e0, e1, e2, e3, e4};
        chk({name, "_len"}, 64'(tx_log.size() - mark), 64'd5);
        for (int i = 0; i < 5; i++)
            if (mark + i < tx_log.size()) chk(name, 64'(tx_log[mark + i]), 64'(e[i]));
    endtask

    task automatic run_random();
        logic [7:0] f[6];
        int rc;
        rc = req_count;
        repeat ($urandom_range(0, 2)) send_garbage();
        if ($urandom_range(0, 2) == 0) stray_resp();
        f[0] = {SYNC, 4'($urandom)};
        for (int i = 1; i < 6; i++) f[i] = 8'($urandom);
        start_frame(f, $urandom_range(0, 3), 1'($urandom), 1'b1, $urandom_range(0, 5),
                    $urandom, 1'($urandom));
        finish_frame();
        chk("random_single_req", 64'(req_count - rc), 64'd1);
    endtask

    initial begin
        logic [7:0] f[6];
        int mark;
        int rc;
        int t;

        iRESET_SYNC = 1'b1;
        repeat (3) tick();
        iRESET_SYNC = 1'b0;
        tick();

        // Read of target 5, core acks after 2 cycles
        mark = tx_log.size();
        rc = req_count;
        f = '{8'hA0, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
        start_frame(f, 0, 1'b0, 1'b1, 2, 32'h12345678, 1'b0);
        finish_frame();
        chk("a_req_count", 64'(req_count - rc), 64'd1);
        chk("a_command", 64'(acc_cmd), 64'(CORE_DEBUG_CMD_READ));
        chk("a_target", 64'(acc_tgt), 64'h05);
        check_tx("a_tx", mark, 8'h50, 8'h12, 8'h34, 8'h56, 8'h78);

        // Two bad header bytes, then STOP
        mark = tx_log.size();
        send_byte(8'h33);
        send_byte(8'h7F);
        f = '{8'hAF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        start_frame(f, 0, 1'b0, 1'b1, 1, 32'h0, 1'b0);
        finish_frame();
        chk("b_drop_count", 64'(oDROP_COUNT), 64'd2);
        chk("b_command", 64'(acc_cmd), 64'(CORE_DEBUG_CMD_STOP));
        check_tx("b_tx", mark, 8'h50, 8'h00, 8'h00, 8'h00, 8'h00);

        // core_debug busy for 10 ISSUE cycles, stray response during ISSUE, error response
        mark = tx_log.size();
        rc = req_count;
        f = '{8'hA2, 8'h33, 8'h01, 8'h02, 8'h03, 8'h04};
        start_frame(f, 10, 1'b1, 1'b1, 0, 32'hCAFEF00D, 1'b1);
        finish_frame();
        chk("busy_single_req", 64'(req_count - rc), 64'd1);
        chk("busy_accept_cycle", 64'(req_acc_n - req_rise_n), 64'd10);
        chk("busy_data", 64'(acc_data), 64'h01020304);
        check_tx("busy_tx", mark, 8'h51, 8'hCA, 8'hFE, 8'hF0, 8'h0D);

        // No response: timeout closes the command
        mark = tx_log.size();
        f = '{8'hA1, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        start_frame(f, 0, 1'b0, 1'b0, 0, 32'h0, 1'b0);
        finish_frame();
        chk("tmo_command", 64'(acc_cmd), 64'(CORE_DEBUG_CMD_WRITE));
        check_tx("tmo_tx", mark, 8'h52, 8'h00, 8'h00, 8'h00, 8'h00);
        run_random();

        // Randomized frames with link backpressure
        tx_rand = 1'b1;
        repeat (25) run_random();

        // Reset after three RX bytes
        send_byte(8'hA3);
        send_byte(8'h11);
        send_byte(8'h22);
        iRESET_SYNC = 1'b1;
        tick();
        iRESET_SYNC = 1'b0;
        chk("rst_drop_count", 64'(oDROP_COUNT), 64'd0);
        run_random();

        // Reset while the second TX byte is presented
        f = '{8'hA4, 8'h09, 8'h99, 8'h88, 8'h77, 8'h66};
        start_frame(f, 0, 1'b0, 1'b1, 0, 32'hA5A5A5A5, 1'b0);
        t = 0;
        while (exp_tx.size() > 4 && t < 200) begin
            tick();
            t++;
        end
        chk("rst_tx_progress", 64'(exp_tx.size()), 64'd4);
        iRESET_SYNC = 1'b1;
        tick();
        iRESET_SYNC = 1'b0;
        mark = tx_log.size();
        repeat (20) tick();
        chk("rst_no_tx_after", 64'(tx_log.size() - mark), 64'd0);
        tx_rand = 1'b0;
        mark = tx_log.size();
        f = '{8'hA0, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
        start_frame(f, 0, 1'b0, 1'b1, 2, 32'h12345678, 1'b0);
        finish_frame();
        check_tx("rst_next_tx", mark, 8'h50, 8'h12, 8'h34, 8'h56, 8'h78);

        // Drop counter saturation
        repeat (260) send_garbage();
        tick();
        chk("drop_saturated", 64'(oDROP_COUNT), 64'hFF);
        run_random();
        chk("drop_still_saturated", 64'(oDROP_COUNT), 64'hFF);

        repeat (5) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
